// File: rtl/screen_sequencer_pkg.sv
// Shared types and constants for the screen sequencer: classifier state encoding,
// screen-index width, default timing and the target-advance helper.
package screen_sequencer_pkg;

    localparam int unsigned ScreenW           = 3;
    localparam int unsigned LevelSteps        = 8;
    localparam int unsigned DefDebounceCycles = 62500;
    localparam int unsigned DefHoldCycles     = 6250000;
    localparam int unsigned DefNumScreens     = 8;

    typedef enum logic [1:0] {
        StIdle,
        StTiming,
        StHeld
    } cls_state_e;

    // Advance a screen index, wrapping from num-1 back to the home screen.
    function automatic logic [ScreenW-1:0] next_screen(input logic [ScreenW-1:0] cur,
                                                       input int unsigned num);
        if (32'(cur) >= num - 1) begin
            return '0;
        end
        return cur + ScreenW'(1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a consecutive-cycle debouncer for one raw button.
module btn_debounce
    import screen_sequencer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            synced;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;

    assign synced    = sync_q[1];
    assign btn_level = level_q;

    // Any cycle agreeing with the accepted level restarts the count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (synced != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = synced;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_raw};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/screen_sequencer.sv
// Classifies debounced centre-button presses as short presses or holds and steps
// the displayed screen index, committing changes only at frame boundaries.
module screen_sequencer
    import screen_sequencer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned HOLD_CYCLES     = DefHoldCycles,
    parameter int unsigned NUM_SCREENS     = DefNumScreens
) (
    input  logic               CLOCK,
    input  logic               rst_n,
    input  logic               btn_c,
    input  logic               frame_begin,
    output logic [ScreenW-1:0] screen_sel,
    output logic               press_evt,
    output logic               hold_evt,
    output logic [2:0]         hold_level
);

    localparam int unsigned HoldW      = $clog2(HOLD_CYCLES);
    localparam int unsigned StepCycles = HOLD_CYCLES / LevelSteps;
    localparam int unsigned StepW      = (StepCycles > 1) ? $clog2(StepCycles) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
    localparam logic [StepW-1:0] StepLast = StepW'(StepCycles - 1);

    logic               btn_db;
    cls_state_e         state_q, state_d;
    logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [StepW-1:0]   step_q, step_d;
    logic [2:0]         level_q, level_d;
    logic [ScreenW-1:0] target_q, target_d;
    logic [ScreenW-1:0] screen_sel_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk      (CLOCK),
        .rst_n    (rst_n),
        .btn_raw  (btn_c),
        .btn_level(btn_db)
    );

    // level_q tracks hold_cnt / StepCycles incrementally, avoiding a divider.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        step_d     = step_q;
        level_d    = level_q;
        press_evt  = 1'b0;
        hold_evt   = 1'b0;
        hold_level = 3'd0;
        unique case (state_q)
            StIdle: begin
                if (btn_db) begin
                    state_d    = StTiming;
                    hold_cnt_d = '0;
                    step_d     = '0;
                    level_d    = 3'd0;
                end
            end
            StTiming: begin
                hold_level = level_q;
                // Reaching the hold threshold wins over a simultaneous release.
                if (hold_cnt_q == HoldLast) begin
                    hold_evt = 1'b1;
                    state_d  = StHeld;
                end else if (!btn_db) begin
                    press_evt = 1'b1;
                    state_d   = StIdle;
                end else begin
                    hold_cnt_d = hold_cnt_q + HoldW'(1);
                    if (step_q == StepLast) begin
                        step_d = '0;
                        if (level_q != 3'd7) begin
                            level_d = level_q + 3'd1;
                        end
                    end else begin
                        step_d = step_q + StepW'(1);
                    end
                end
            end
            StHeld: begin
                hold_level = 3'd7;
                if (!btn_db) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        target_d = target_q;
        if (hold_evt) begin
            target_d = '0;
        end else if (press_evt) begin
            target_d = next_screen(target_q, NUM_SCREENS);
        end
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            hold_cnt_q <= '0;
            step_q     <= '0;
            level_q    <= 3'd0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            step_q     <= step_d;
            level_q    <= level_d;
        end
    end

    // screen_sel samples the pre-event target when an event lands on a frame start.
    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            target_q     <= '0;
            screen_sel_q <= '0;
        end else begin
            target_q <= target_d;
            if (frame_begin) begin
                screen_sel_q <= target_q;
            end
        end
    end

    assign screen_sel = screen_sel_q;

endmodule

// File: doc/screen_sequencer.md
SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 62500, consecutive clock cycles a synchronised button level must hold before it is accepted (10 ms at 6.25 MHz).
REQ-002 Parameter HOLD_CYCLES, default 6250000, debounced-high cycles that classify a press as a hold (1 s at 6.25 MHz); SHALL be a multiple of 8 and >= 16.
REQ-003 Parameter NUM_SCREENS, default 8, number of game screens sequenced (2..8).
REQ-004 CLOCK  input  1  single system clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 btn_c  input  1  raw, asynchronous, bouncing centre pushbutton (high = pressed).
REQ-007 frame_begin  input  1  one-cycle pulse from the OLED driver marking the start of a frame.
REQ-008 screen_sel  output  3  index of the screen module whose oled_data is displayed.
REQ-009 press_evt  output  1  one-cycle pulse on a classified short press.
REQ-010 hold_evt  output  1  one-cycle pulse on a classified hold.
REQ-011 hold_level  output  3  hold progress 0..7 for on-screen progress drawing.

Function
REQ-012 btn_c SHALL pass through a two-flop synchroniser; the synchronised value is the only use of btn_c.
REQ-013 Debounce: debounced level SHALL change only after DEBOUNCE_CYCLES consecutive cycles of synchronised level differing from it; any agreeing cycle clears the counter.
REQ-014 Classifier FSM states IDLE, TIMING, HELD; IDLE->TIMING on debounced rise; hold counter cleared on entry.
REQ-015 In TIMING the hold counter SHALL increment each cycle; debounced fall before count reaches HOLD_CYCLES-1 -> press_evt for one cycle, go IDLE.
REQ-016 In TIMING with count == HOLD_CYCLES-1 and button still high -> hold_evt for one cycle, go HELD; a fall on that same cycle SHALL yield hold_evt, not press_evt.
REQ-017 HELD -> IDLE on debounced fall with no event; at most one event per physical press.
REQ-018 hold_level SHALL equal hold_count / (HOLD_CYCLES/8) in TIMING (saturating at 7), 7 in HELD, 0 in IDLE.
REQ-019 A target register SHALL advance on press_evt: target+1, wrapping from NUM_SCREENS-1 to 0.
REQ-020 hold_evt SHALL set target to 0 (return to home screen).
REQ-021 screen_sel SHALL load target only on cycles where frame_begin = 1, so the screen changes only at frame boundaries.
REQ-022 Event and frame_begin in the same cycle: screen_sel loads the pre-event target; the new target is applied at the next frame_begin.
REQ-023 Several events between two frame_begin pulses SHALL all accumulate into target.
REQ-024 press_evt and hold_evt SHALL never be high together.

Reset
REQ-025 On rst_n low, all registers clear immediately: screen_sel=0, target=0, press_evt=0, hold_evt=0, hold_level=0, FSM=IDLE, synchroniser, debounce and hold counters=0, debounced level=0.
REQ-026 Button held across reset release SHALL be treated as a fresh press after DEBOUNCE_CYCLES.

Structure
REQ-027 Shared package holds the FSM state encoding, the screen-index width (3) and the default timing constants.
REQ-028 Synchroniser plus debouncer SHALL be one sub-module, btn_debounce, parameterised by DEBOUNCE_CYCLES.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, NUM_SCREENS=8)
REQ-029 Bench: btn_c high 10 cycles then low, with 3-cycle bounce at each edge -> exactly one press_evt; target 0->1; screen_sel=1 on the cycle after the next frame_begin.
REQ-030 Bench: btn_c high 40 cycles -> one hold_evt 16 cycles after debounced rise; hold_level steps 0..7 every 2 cycles; no press_evt on release; target=0.
REQ-031 Bench: 8 short presses with no frame_begin, then one frame_begin -> target wraps 0..7..0; screen_sel goes 0 -> 0.
REQ-032 Bench: press_evt coincident with frame_begin while target=2 -> screen_sel=2, then 3 at the following frame_begin.
REQ-033 Bench: rst_n low mid-TIMING with screen_sel=5 -> all outputs 0 asynchronously; with button still high, press_evt only after release following a fresh debounce.
